// File: rtl/waveform_gen_pkg.sv
// Shared types and constants for the multi-channel waveform generator.
// Holds sample/LUT geometry, the waveform selector, the per-channel
// configuration record, the reset configuration and the sine lookup.
// The configuration record is sized by CFG_SEL_W / CFG_AMP_W / CFG_PH_W;
// the generator's SEL_WIDTH and AMP_W parameters are expected to match them.
package waveform_gen_pkg;

  localparam int LUT_WIDTH = 12;
  localparam int LUT_SIZE  = 64;
  localparam int CNT_WIDTH = 8;
  localparam int LUT_AW    = $clog2(LUT_SIZE);

  localparam int CFG_SEL_W = 8;
  localparam int CFG_AMP_W = 8;
  localparam int CFG_PH_W  = CFG_SEL_W + LUT_AW;

  typedef enum logic [1:0] {
    SINE_WAVE        = 2'd0,
    TRIANGULAR_WAVE  = 2'd1,
    SAWTOOTH_WAVE    = 2'd2,
    RECTANGULAR_WAVE = 2'd3
  } wave_sel_t;

  typedef struct packed {
    logic [CFG_SEL_W-1:0] freq_sel;
    wave_sel_t            wave_sel;
    logic [CNT_WIDTH-1:0] duty;
    logic [CFG_PH_W-1:0]  phase;
    logic [CFG_AMP_W-1:0] amp;
    logic                 saw_reverse;
  } wg_cfg_t;

  // Power-on configuration: silent-start sine at unity gain, 50% duty.
  function automatic wg_cfg_t wg_reset_cfg();
    wg_cfg_t c;
    c.freq_sel    = '0;
    c.wave_sel    = SINE_WAVE;
    c.duty        = CNT_WIDTH'(2 ** (CNT_WIDTH - 1));
    c.phase       = '0;
    c.amp         = CFG_AMP_W'(2 ** (CFG_AMP_W - 1));
    c.saw_reverse = 1'b0;
    return c;
  endfunction

  // First quadrant of a 64-point sine, amplitude 2047; k = 0..16.
  function automatic logic signed [LUT_WIDTH-1:0] quarter_sine(input logic [4:0] k);
    logic signed [LUT_WIDTH-1:0] v;
    case (k)
      5'd0:    v = 12'sd0;
      5'd1:    v = 12'sd201;
      5'd2:    v = 12'sd399;
      5'd3:    v = 12'sd594;
      5'd4:    v = 12'sd783;
      5'd5:    v = 12'sd965;
      5'd6:    v = 12'sd1137;
      5'd7:    v = 12'sd1299;
      5'd8:    v = 12'sd1447;
      5'd9:    v = 12'sd1582;
      5'd10:   v = 12'sd1702;
      5'd11:   v = 12'sd1805;
      5'd12:   v = 12'sd1891;
      5'd13:   v = 12'sd1959;
      5'd14:   v = 12'sd2008;
      5'd15:   v = 12'sd2037;
      default: v = 12'sd2047;
    endcase
    return v;
  endfunction

  // Full-cycle sine built from the quarter table by mirroring:
  // idx[4] mirrors within the half, idx[5] negates the second half.
  function automatic logic signed [LUT_WIDTH-1:0] sine_lut(input logic [LUT_AW-1:0] idx);
    logic [4:0]                  k;
    logic signed [LUT_WIDTH-1:0] m;
    k = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    m = quarter_sine(k);
    return idx[5] ? -m : m;
  endfunction

endpackage

// File: rtl/waveform_gen_chan.sv
// One generator channel: phase accumulator, active/shadow configuration
// with pending flag, waveform shaping and amplitude scaling.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg_wr       handshake strobe for this channel (only when !pending)
//   cfg          configuration written into the shadow on cfg_wr
//   halt         freezes the accumulator
//   sync         clears the accumulator and applies a pending shadow
//   wave         scaled sample, two cycles behind the accumulator
//   wrap         one-cycle pulse after an accumulator carry-out
//   pending      shadow holds a configuration not yet applied
module waveform_gen_chan
  import waveform_gen_pkg::*;
#(
  parameter int PH_W  = CFG_PH_W,
  parameter int AMP_W = CFG_AMP_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_wr,
  input  wg_cfg_t                     cfg,
  input  logic                        halt,
  input  logic                        sync,
  output logic signed [LUT_WIDTH-1:0] wave,
  output logic                        wrap,
  output logic                        pending
);

  localparam int PH_W1 = PH_W + 1;
  localparam int PW    = LUT_WIDTH + AMP_W + 1;
  localparam logic signed [LUT_WIDTH-1:0] POS_MAX = LUT_WIDTH'(2 ** (LUT_WIDTH - 1) - 1);
  localparam logic signed [LUT_WIDTH-1:0] NEG_MAX = -POS_MAX;
  localparam logic signed [PW-1:0]        SAT_HI  = PW'(2 ** (LUT_WIDTH - 1) - 1);
  localparam logic signed [PW-1:0]        SAT_LO  = -SAT_HI - PW'(1);

  wg_cfg_t                     act;
  wg_cfg_t                     shd;
  logic [PH_W-1:0]             acc;
  logic [PH_W:0]               acc_sum;
  logic                        carry;
  logic [PH_W-1:0]             ph;
  logic signed [LUT_WIDTH-1:0] raw_c;
  logic signed [LUT_WIDTH-1:0] raw_p1;
  logic [AMP_W-1:0]            amp_p1;
  logic signed [LUT_WIDTH-1:0] wave_p2;

  function automatic logic signed [LUT_WIDTH-1:0] raw_sample(input logic [PH_W-1:0] p,
                                                             input wg_cfg_t c);
    logic [LUT_WIDTH-1:0]        t;
    logic signed [LUT_WIDTH-1:0] r;
    t = '0;
    r = '0;
    case (c.wave_sel)
      SINE_WAVE: r = sine_lut(p[PH_W-1 -: LUT_AW]);
      TRIANGULAR_WAVE: begin
        // One full ramp per half-period; the second half walks it backwards.
        t = p[PH_W-2 -: LUT_WIDTH];
        if (p[PH_W-1]) t = ~t;
        r = {~t[LUT_WIDTH-1], t[LUT_WIDTH-2:0]};
      end
      SAWTOOTH_WAVE: begin
        // Offset-binary ramp turned two's complement by flipping the MSB.
        t = p[PH_W-1 -: LUT_WIDTH];
        r = {~t[LUT_WIDTH-1], t[LUT_WIDTH-2:0]};
        if (c.saw_reverse) r = ~r;
      end
      default: r = (p[PH_W-1 -: CNT_WIDTH] < c.duty) ? POS_MAX : NEG_MAX;
    endcase
    return r;
  endfunction

  function automatic logic signed [LUT_WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
    if (v > SAT_HI) return POS_MAX;
    if (v < SAT_LO) return LUT_WIDTH'(SAT_LO);
    return LUT_WIDTH'(v);
  endfunction

  // amp is unsigned with unity at 2**(AMP_W-1); the shift floors toward -inf.
  function automatic logic signed [LUT_WIDTH-1:0] scale_sat(input logic signed [LUT_WIDTH-1:0] s,
                                                            input logic [AMP_W-1:0] a);
    logic signed [PW-1:0] prod;
    prod = PW'(s) * PW'($signed({1'b0, a}));
    return saturate(prod >>> (AMP_W - 1));
  endfunction

  assign acc_sum = {1'b0, acc} + {1'b0, PH_W'(act.freq_sel)} + PH_W1'(1);
  assign carry   = acc_sum[PH_W];
  assign ph      = acc + PH_W'(act.phase);
  assign raw_c   = raw_sample(ph, act);
  assign wave    = wave_p2;

  // Stage 0: accumulator and configuration bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      wrap    <= 1'b0;
      act     <= wg_reset_cfg();
      shd     <= wg_reset_cfg();
      pending <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (sync) begin
        acc <= '0;
      end else if (!halt) begin
        acc  <= acc_sum[PH_W-1:0];
        wrap <= carry;
      end
      // A handshake is only offered while nothing is pending, so apply and
      // capture never compete; a capture alongside sync stays pending.
      if (pending && (sync || (!halt && carry))) begin
        act     <= shd;
        pending <= 1'b0;
      end else if (cfg_wr) begin
        shd     <= cfg;
        pending <= 1'b1;
      end
    end
  end

  // Stage 1: raw waveform sample, with the gain that belongs to it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_p1 <= '0;
      amp_p1 <= '0;
    end else begin
      raw_p1 <= raw_c;
      amp_p1 <= AMP_W'(act.amp);
    end
  end

  // Stage 2: scaled and saturated output sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_p2 <= '0;
    end else begin
      wave_p2 <= scale_sat(raw_p1, amp_p1);
    end
  end

endmodule

// File: rtl/waveform_gen_mc.sv
// Multi-channel waveform generator top level.
// Routes configuration handshakes to the addressed channel, muxes the
// ready back, and fans halt/sync out to N_CH independent channels.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cfg_valid     configuration write request
//   cfg_ready_o   write accepted this cycle when high together with cfg_valid
//   cfg_chan      target channel; out-of-range values are never ready
//   cfg           configuration record
//   halt          per-channel accumulator freeze
//   sync          global phase restart and apply of pending configurations
//   wave_o        per-channel signed samples
//   wrap_o        per-channel wrap pulses
module waveform_gen_mc
  import waveform_gen_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int SEL_WIDTH = CFG_SEL_W,
  parameter  int AMP_W     = CFG_AMP_W,
  localparam int PH_W      = SEL_WIDTH + $clog2(LUT_SIZE),
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready_o,
  input  logic [CH_W-1:0]             cfg_chan,
  input  wg_cfg_t                     cfg,
  input  logic [N_CH-1:0]             halt,
  input  logic                        sync,
  output logic signed [LUT_WIDTH-1:0] wave_o [N_CH],
  output logic [N_CH-1:0]             wrap_o
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;

  // A cfg_chan matching no channel leaves ready low and writes nothing.
  always_comb begin
    cfg_ready_o = 1'b0;
    wr          = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_chan == CH_W'(i)) begin
        cfg_ready_o = !pend[i];
        wr[i]       = cfg_valid && !pend[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    waveform_gen_chan #(
      .PH_W  (PH_W),
      .AMP_W (AMP_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .cfg_wr  (wr[g]),
      .cfg     (cfg),
      .halt    (halt[g]),
      .sync    (sync),
      .wave    (wave_o[g]),
      .wrap    (wrap_o[g]),
      .pending (pend[g])
    );
  end

endmodule

// File: doc/waveform_gen_mc.md
WAVEFORM_GEN_MC -- requirements
Module: waveform_gen_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent channels (1..16).
REQ-002 SHALL have parameter SEL_WIDTH, default 8, frequency-select width.
REQ-003 SHALL have parameter AMP_W, default 8, amplitude-scale width; 2**(AMP_W-1) = unity gain.
REQ-004 SHALL derive localparams PH_W = SEL_WIDTH + $clog2(LUT_SIZE) and CH_W = max(1, $clog2(N_CH)).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port cfg_valid, input, 1, configuration write request.
REQ-008 SHALL have port cfg_ready_o, output, 1, configuration write accepted this cycle when high with cfg_valid.
REQ-009 SHALL have port cfg_chan, input, CH_W, target channel.
REQ-010 SHALL have port cfg, input, wg_cfg_t, fields: freq_sel[SEL_WIDTH], wave_sel (wave_sel_t), duty[CNT_WIDTH], phase[PH_W], amp[AMP_W], saw_reverse.
REQ-011 SHALL have port halt, input, N_CH, per-channel freeze.
REQ-012 SHALL have port sync, input, 1, global phase restart.
REQ-013 SHALL have port wave_o, output, N_CH x LUT_WIDTH signed, per-channel sample.
REQ-014 SHALL have port wrap_o, output, N_CH, one-cycle pulse on accumulator wrap.

Function
REQ-015 Each channel SHALL hold a PH_W-bit accumulator; when not halted, acc <= acc + freq_sel + 1, modulo 2**PH_W. Period = 2**PH_W / (freq_sel+1) cycles.
REQ-016 Index phase SHALL be acc + active phase, modulo 2**PH_W; lut index = top $clog2(LUT_SIZE) bits.
REQ-017 SINE SHALL output the package sine LUT at index.
REQ-018 TRIANGULAR SHALL rise monotonically from most-negative to most-positive over the first half-period and fall over the second half-period.
REQ-019 SAWTOOTH SHALL rise from most-negative to most-positive over one period; with saw_reverse=1, it SHALL fall instead (bitwise inversion of the ramp).
REQ-020 RECTANGULAR SHALL output +max when the top CNT_WIDTH phase bits < duty, else -max. duty=0 gives constant -max.
REQ-021 Raw sample SHALL be multiplied by amp and arithmetically shifted right by AMP_W-1, saturating to the signed LUT_WIDTH range.
REQ-022 Latency from an accumulator update to the corresponding wave_o SHALL be exactly 2 cycles: registered raw sample, then registered scaled sample.
REQ-023 Each channel SHALL keep an active and a shadow config plus a pending flag.
REQ-024 cfg_ready_o SHALL equal !pending[cfg_chan] and SHALL be 0 when cfg_chan >= N_CH; a handshake writes the shadow and sets pending.
REQ-025 Pending shadow SHALL copy to active in the cycle the channel wraps, or on sync; pending then clears and the next handshake is possible the following cycle.
REQ-026 halt[i] SHALL freeze acc[i]; wave_o[i] SHALL hold its last value 2 cycles later, and wrap_o[i] SHALL stay 0.
REQ-027 sync SHALL clear every accumulator to 0 and apply every pending shadow, overriding halt in that cycle; wrap_o SHALL not pulse for sync.
REQ-028 A handshake in the same cycle as sync SHALL land in the shadow and stay pending; it is not applied by that sync.
REQ-029 wrap_o[i] SHALL pulse when acc + inc carries out of PH_W bits, aligned with the update that wraps.

Reset
REQ-030 On rst_n low SHALL set: accumulators 0; active = {freq_sel 0, SINE_WAVE, duty 2**(CNT_WIDTH-1), phase 0, amp 2**(AMP_W-1), saw_reverse 0}; shadows equal active; pending 0; pipeline registers, wave_o and wrap_o 0.
REQ-031 cfg_ready_o SHALL be 1 from the first cycle after reset release for any valid cfg_chan.
REQ-032 Reset asserted mid-operation SHALL discard pending configs and restore the REQ-030 values immediately.

Structure
REQ-033 waveform_gen_pkg SHALL hold LUT_WIDTH, LUT_SIZE, CNT_WIDTH, wave_sel_t, the sine LUT function and wg_cfg_t.
REQ-034 Per-channel logic SHALL live in sub-module waveform_gen_chan, instantiated N_CH times by generate; the top module holds only the config demux, ready mux and sync fan-out.

Verification
REQ-035 Reset, then write ch0 freq_sel=255 SINE -> wrap_o[0] pulses every LUT_SIZE cycles after the first applied wrap.
REQ-036 ch0 and ch1 SAWTOOTH freq_sel=255, ch1 phase=2**(PH_W-1), then sync -> wave_o[1] equals wave_o[0] shifted by LUT_SIZE/2 cycles.
REQ-037 Second write to ch2 before wrap -> cfg_ready_o=0 for ch2 until its wrap, then 1 the next cycle; cfg_ready_o=1 for ch3 throughout.
REQ-038 RECTANGULAR, duty=0.7*(2**CNT_WIDTH-1), 10 periods -> high fraction within 1% of 0.7; duty=0 -> constant -max.
REQ-039 amp=2**(AMP_W-1) vs amp=2**(AMP_W-2) on SINE -> second peak equals first peak >>> 1; amp=2**AMP_W-1 saturates without sign flip.
REQ-040 Assert halt[0] for 100 cycles -> wave_o[0] constant and no wrap_o[0] pulse; sync during halt -> acc 0, resumes from phase offset after release.
